pipelined_addsub_acc: RTL and testbench
=======================================

# pipelined_addsub_acc

Parametrised, pipelined signed adder/subtractor with an accumulator mode, valid/ready flow control, a per-result overflow flag and a sticky overflow flag. It is the streaming successor to the single-cycle 16-bit signed add/sub datapath block. It sits between a producer, such as switch/register-file operand logic, and a consumer, such as a display or memory write stage, that may stall.

## Interface
Parameters:
- WIDTH, 16: operand, result and accumulator width in bits, two's complement; legal range 2..64.

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Resetn  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- mode  in  2  operation: 00 = a+b, 01 = a−b, 10 = acc+b, 11 = acc−b. Captured with the beat.
- dataa  in  WIDTH  operand A, signed; ignored in modes 1x.
- datab  in  WIDTH  operand B, signed.
- clear  in  1  zero the accumulator and the sticky flag; independent of handshake.
- out_valid  out  1  result beat available.
- out_ready  in  1  consumer takes the beat.
- result  out  WIDTH  signed result.
- overflow  out  1  signed overflow of this result beat.
- acc  out  WIDTH  current accumulator value.
- overflow_sticky  out  1  set by any overflowing beat; cleared only by clear or reset.

## Operation
- **Pipeline structure.** Two register stages.
  - S1 captures mode, dataa and datab on acceptance.
  - S2 computes and registers result and overflow.
- **Stage enables.**
  - en2 = !s2_valid | out_ready.
  - en1 = !s1_valid | en2.
  - in_ready = en1.
  - Acceptance occurs when in_valid & in_ready.
- **Arithmetic.**
  - Compute in WIDTH+1 bits.
  - Subtraction is a + ~b + 1.
  - For modes 1x, the left operand is the acc register value at the cycle S2 loads. Back-to-back accumulate beats therefore chain correctly with no bubble.
  - overflow = operands' sign bits imply a same-sign sum whose sign differs. Equivalently, for subtraction, a and b have different signs and the result sign differs from a.
- **Accumulator update.** Whenever S2 loads a mode-1x beat, acc takes the (possibly saturated) result value.
  - Modes 0x never modify acc.
- **overflow_sticky.** Sets when S2 loads a beat with overflow=1.
- **clear.**
  - The same cycle as an S2 accumulate load: acc loads 0 and sticky loads 0 (clear wins). The result register still gets the computed value.
  - Pipeline contents are unaffected.
- **Ordering.** No beat is dropped or duplicated; results leave in acceptance order.
- **Stall holding.** While out_valid & !out_ready, result and overflow are held stable.

## Timing
- **Reset values.** With Resetn low at an edge, S1 and S2 valids clear and acc, result, overflow, overflow_sticky all clear to 0. As a result:
  - out_valid = 0.
  - in_ready = 1 from the first cycle after reset.
- **Reset mid-operation.** In-flight beats are discarded; nothing is emitted afterwards for them.
- **Latency.** A beat accepted at edge N appears with out_valid=1 after edge N+1, given no stall.
- **Throughput.** One beat per cycle while out_ready=1.
- **Full pipeline.** When both stages are valid and out_ready=0, in_ready=0 combinationally.
- **Simultaneous events.** When the pipeline is full and out_ready rises, the block accepts a new beat in that same cycle.
- **Wrap-around.** Without saturation, results wrap modulo 2^WIDTH.

## Configuration
- **ADDSUB_SATURATE_EN defined.** On overflow, result is clamped: positive overflow gives 2^(WIDTH−1)−1 and negative overflow gives −2^(WIDTH−1).
  - acc loads the clamped value.
  - overflow still reads 1.
- **ADDSUB_SATURATE_EN undefined.** result and acc take the wrapped sum; the clamp logic is absent.

## Test plan
- **Add with overflow.** WIDTH=16, mode 00, 0x7FFF + 0x0001 → result 0x8000, overflow=1, sticky=1; with ADDSUB_SATURATE_EN, result 0x7FFF.
- **Subtract and latency.** Mode 01, 0x0005 − 0x0007 accepted at edge N → out_valid after edge N+1, result 0xFFFE, overflow=0.
- **Back-to-back accumulate.** clear, then mode 10 with datab 10, 20, −5 on consecutive cycles → results 10, 30, 25; acc = 25; then mode 11 with datab 25 → 0.
- **Backpressure.**
  - Stimulus: out_ready=0 with in_valid held high for 4 cycles.
  - Required: exactly 2 beats accepted and in_ready=0 afterwards.
  - Then out_ready=1: all accepted beats emerge in order, result held stable during the stall.
- **Clear collision.** clear asserted the same cycle an acc+5 beat loads S2 → that result shows old acc+5, and acc reads 0 next cycle; sticky is cleared.
- **Reset mid-stream.** Resetn low for one edge with both stages valid → out_valid=0, acc=0, in_ready=1 next cycle; no stale beat is emitted.

Source files
------------

// File: rtl/pipelined_addsub_acc.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_acc
//
// Two-stage pipelined signed adder/subtractor with an accumulator mode,
// valid/ready flow control, a per-beat overflow flag and a sticky overflow
// flag. This is the streaming successor to the single-cycle 16-bit add/sub
// datapath.
//
//   S1 : registers mode, dataa and datab when a beat is accepted.
//   S2 : computes the sum in WIDTH+1 bits and registers result/overflow.
//        Accumulate beats (mode 1x) also update acc here.
//
// Parameters
//   WIDTH            operand/result/accumulator width, two's complement (2..64)
//
// Optional feature macro
//   ADDSUB_SATURATE_EN  when defined, overflowing results clamp to the most
//                       positive / most negative value (acc loads the clamped
//                       value, overflow still reads 1). When undefined,
//                       results wrap modulo 2^WIDTH.
//
// Ports
//   Clock            in   sole clock, rising edge
//   Resetn           in   synchronous active-low reset
//   in_valid         in   operand beat offered
//   in_ready         out  beat accepted this cycle (in_valid & in_ready)
//   mode[1:0]        in   00 a+b, 01 a-b, 10 acc+b, 11 acc-b
//   dataa[WIDTH]     in   operand A (ignored in modes 1x)
//   datab[WIDTH]     in   operand B
//   clear            in   zero acc and overflow_sticky (handshake independent)
//   out_valid        out  result beat available
//   out_ready        in   consumer takes the beat
//   result[WIDTH]    out  signed result
//   overflow         out  signed overflow of this result beat
//   acc[WIDTH]       out  current accumulator value
//   overflow_sticky  out  set by any overflowing beat; cleared by clear/reset
// -----------------------------------------------------------------------------
module pipelined_addsub_acc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] acc,
    output logic             overflow_sticky
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;

    logic             en1;
    logic             en2;

    // ------------------------------------------------------------------
    // Stage enables: a stage may load when it is empty or when the stage
    // downstream of it is moving. in_ready is purely combinational so a
    // full pipeline accepts a new beat in the same cycle out_ready rises.
    // ------------------------------------------------------------------
    always_comb begin
        en2 = !s2_valid | out_ready;
        en1 = !s1_valid | en2;
    end

    assign in_ready  = en1;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // S2 arithmetic
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic             cin;
    logic [WIDTH:0]   sum_ext;
    logic             ovf;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        // Accumulate modes read the live acc register, which S2 updates on
        // the same edge it loads, so consecutive accumulate beats chain.
        lhs = s1_mode[1] ? acc : s1_a;
        // Subtraction as a + ~b + 1.
        rhs = s1_mode[0] ? ~s1_b : s1_b;
        cin = s1_mode[0];

        // Sign-extended WIDTH+1 bit sum: the top two bits disagree exactly
        // when the WIDTH-bit result has overflowed, and bit WIDTH then holds
        // the true sign of the result.
        sum_ext = {lhs[WIDTH-1], lhs} + {rhs[WIDTH-1], rhs}
                + {{WIDTH{1'b0}}, cin};
        ovf     = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];

        res_next = sum_ext[WIDTH-1:0];
`ifdef ADDSUB_SATURATE_EN
        if (ovf) begin
            if (sum_ext[WIDTH])
                res_next = {1'b1, {(WIDTH-1){1'b0}}};   // most negative
            else
                res_next = {1'b0, {(WIDTH-1){1'b1}}};   // most positive
        end
`endif
    end

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            s1_valid <= 1'b0;
            s1_mode  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= mode;
                s1_a    <= dataa;
                s1_b    <= datab;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: result, overflow, accumulator and sticky flag
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            s2_valid        <= 1'b0;
            result          <= '0;
            overflow        <= 1'b0;
            acc             <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (en2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result   <= res_next;
                    overflow <= ovf;
                    if (s1_mode[1])
                        acc <= res_next;
                    if (ovf)
                        overflow_sticky <= 1'b1;
                end
            end
            // clear takes priority over a same-cycle accumulate load; the
            // result register above still receives the computed value.
            if (clear) begin
                acc             <= '0;
                overflow_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub_acc.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub_acc
//
// Directed bench for pipelined_addsub_acc at WIDTH=16. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub_acc;

    localparam int unsigned W = 16;

    logic         Clock;
    logic         Resetn;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] dataa;
    logic [W-1:0] datab;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic [W-1:0] acc;
    logic         overflow_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_addsub_acc #(.WIDTH(W)) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .mode            (mode),
        .dataa           (dataa),
        .datab           (datab),
        .clear           (clear),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result          (result),
        .overflow        (overflow),
        .acc             (acc),
        .overflow_sticky (overflow_sticky)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int accepted;

    initial begin
        Resetn    = 1'b0;
        in_valid  = 1'b0;
        mode      = 2'b00;
        dataa     = '0;
        datab     = '0;
        clear     = 1'b0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_acc", acc, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sticky", overflow_sticky, 0);
        Resetn = 1'b1;
        step();

        // ---------------- add with overflow ----------------
        in_valid = 1'b1; mode = 2'b00; dataa = 16'h7FFF; datab = 16'h0001;
        step();
        in_valid = 1'b0;
        check("add_not_yet_valid", out_valid, 0);
        step();
        check("add_out_valid", out_valid, 1);
`ifdef ADDSUB_SATURATE_EN
        check("add_result", result, 16'h7FFF);
`else
        check("add_result", result, 16'h8000);
`endif
        check("add_overflow", overflow, 1);
        check("add_sticky", overflow_sticky, 1);
        check("add_acc_untouched", acc, 0);

        // ---------------- subtract and latency ----------------
        in_valid = 1'b1; mode = 2'b01; dataa = 16'h0005; datab = 16'h0007;
        step();                                     // edge N
        in_valid = 1'b0;
        check("sub_not_yet_valid", out_valid, 0);
        step();                                     // edge N+1
        check("sub_out_valid", out_valid, 1);
        check("sub_result", result, 16'hFFFE);
        check("sub_overflow", overflow, 0);
        check("sub_sticky_kept", overflow_sticky, 1);

        // ---------------- back-to-back accumulate ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_acc", acc, 0);
        check("clr_sticky", overflow_sticky, 0);
        in_valid = 1'b1; mode = 2'b10; dataa = 16'h1234; datab = 16'd10;
        step();
        datab = 16'd20;
        step();
        check("acc1_result", result, 16'd10);
        check("acc1_acc", acc, 16'd10);
        datab = 16'hFFFB;                           // -5
        step();
        check("acc2_result", result, 16'd30);
        check("acc2_acc", acc, 16'd30);
        mode = 2'b11; datab = 16'd25;
        step();
        check("acc3_result", result, 16'd25);
        check("acc3_acc", acc, 16'd25);
        in_valid = 1'b0;
        step();
        check("acc4_result", result, 16'd0);
        check("acc4_acc", acc, 16'd0);
        check("acc4_overflow", overflow, 0);
        step();
        check("acc_drained", out_valid, 0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        accepted  = 0;
        in_valid  = 1'b1; mode = 2'b00; datab = 16'd1;
        for (int i = 0; i < 4; i++) begin
            dataa = 16'(100 + i);
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted, 2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_first_result", result, 16'd101);
        step();
        check("bp_result_held", result, 16'd101);
        check("bp_in_ready_still_low", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_same_cycle", in_ready, 1);
        in_valid = 1'b1; dataa = 16'd500; datab = 16'd1;
        step();
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1);
        check("bp_second_result", result, 16'd102);
        step();
        check("bp_third_valid", out_valid, 1);
        check("bp_third_result", result, 16'd501);
        step();
        check("bp_drained", out_valid, 0);

        // ---------------- clear collision ----------------
        in_valid = 1'b1; mode = 2'b00; dataa = 16'h7FFF; datab = 16'h0001;
        step();
        mode = 2'b10; datab = 16'd7;
        step();                                     // overflow beat loads S2
        datab = 16'd5;
        step();                                     // acc+7 loads S2
        in_valid = 1'b0;
        check("col_pre_acc", acc, 16'd7);
        check("col_pre_sticky", overflow_sticky, 1);
        clear = 1'b1;
        step();                                     // acc+5 loads S2 with clear
        clear = 1'b0;
        check("col_result", result, 16'd12);
        check("col_out_valid", out_valid, 1);
        check("col_acc", acc, 0);
        check("col_sticky", overflow_sticky, 0);
        step();
        check("col_drained", out_valid, 0);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 2'b10; datab = 16'd3;
        step();
        datab = 16'd4;
        step();
        in_valid = 1'b0;
        check("mid_full_valid", out_valid, 1);
        check("mid_full_in_ready", in_ready, 0);
        check("mid_full_acc", acc, 16'd3);
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_acc", acc, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_result", result, 0);
        out_ready = 1'b1;
        step();
        check("mid_no_stale_1", out_valid, 0);
        step();
        check("mid_no_stale_2", out_valid, 0);
        check("mid_acc_stays", acc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
